// File: rtl/vga_capture.sv
// Frame grabber: recovers raster position from hsync/vsync, samples the centre
// pixel of each cell and commits the rebuilt cell grid once per clean frame.
module vga_capture #(
  parameter int H_TOTAL  = 800,
  parameter int H_VBEGIN = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_VBEGIN = 35,
  parameter int V_ACTIVE = 480,
  parameter int CELL     = 10,
  localparam int GW      = H_ACTIVE / CELL,
  localparam int NBITS   = GW * (V_ACTIVE / CELL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [3:0]       r_in,
  input  logic [3:0]       g_in,
  input  logic [3:0]       b_in,
  output logic [NBITS-1:0] state,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int IDX_W = $clog2(NBITS);
  localparam int SUB_W = $clog2(CELL);
  localparam logic [9:0] CNT_MAX = 10'd1023;
  localparam logic [9:0] H_BEG   = 10'(H_VBEGIN);
  localparam logic [9:0] H_END   = 10'(H_VBEGIN + H_ACTIVE);
  localparam logic [9:0] V_BEG   = 10'(V_VBEGIN);
  localparam logic [9:0] V_END   = 10'(V_VBEGIN + V_ACTIVE);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(CELL / 2);
  localparam logic [15:0] GW16 = 16'(GW);

  typedef enum logic {SEARCH, CAPTURE} fsm_t;
  fsm_t fsm;

  logic             hsync_s1, hsync_s2, vsync_s1, vsync_s2;
  logic [2:0]       rgb_s1;
  logic             h_fall, v_fall;
  logic [9:0]       col_q, col_cur, row_q, row_cur;
  logic [SUB_W-1:0] hsub_q, hsub_cur, vsub_q, vsub_cur;
  logic [9:0]       ccol_q, ccol_cur;
  logic [15:0]      rbase_q, rbase_cur;
  logic             sample;
  logic [IDX_W-1:0] idx;
  logic [NBITS-1:0] cap_buf;
  logic             unused_rgb;

  // Only the colour MSBs decide whether a cell is lit.
  assign unused_rgb = ^{r_in[2:0], g_in[2:0], b_in[2:0]};

  // s1/s2 input stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_s1 <= 1'b0;
      hsync_s2 <= 1'b0;
      vsync_s1 <= 1'b0;
      vsync_s2 <= 1'b0;
      rgb_s1   <= '0;
    end else begin
      hsync_s1 <= hsync;
      hsync_s2 <= hsync_s1;
      vsync_s1 <= vsync;
      vsync_s2 <= vsync_s1;
      rgb_s1   <= {r_in[3], g_in[3], b_in[3]};
    end
  end

  // Position of the pixel currently held in the s1 stage.
  always_comb begin
    h_fall    = hsync_s2 & ~hsync_s1;
    v_fall    = vsync_s2 & ~vsync_s1;
    col_cur   = h_fall ? '0 : ((col_q == CNT_MAX) ? CNT_MAX : col_q + 10'd1);
    row_cur   = row_q;
    vsub_cur  = vsub_q;
    rbase_cur = rbase_q;
    if (h_fall) begin
      if (v_fall)
        row_cur = '0;
      else if (row_q != CNT_MAX)
        row_cur = row_q + 10'd1;
      if (row_cur == V_BEG) begin
        vsub_cur  = '0;
        rbase_cur = '0;
      end else if (vsub_q == SUB_LAST) begin
        vsub_cur  = '0;
        rbase_cur = rbase_q + GW16;
      end else begin
        vsub_cur  = vsub_q + SUB_W'(1);
      end
    end
    if (col_cur == H_BEG) begin
      hsub_cur = '0;
      ccol_cur = '0;
    end else if (hsub_q == SUB_LAST) begin
      hsub_cur = '0;
      ccol_cur = ccol_q + 10'd1;
    end else begin
      hsub_cur = hsub_q + SUB_W'(1);
      ccol_cur = ccol_q;
    end
    sample = (col_cur >= H_BEG) && (col_cur < H_END) &&
             (row_cur >= V_BEG) && (row_cur < V_END) &&
             (hsub_cur == SUB_MID) && (vsub_cur == SUB_MID);
    idx    = IDX_W'(rbase_cur + {6'd0, ccol_cur});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      hsub_q  <= '0;
      vsub_q  <= '0;
      ccol_q  <= '0;
      rbase_q <= '0;
    end else begin
      col_q   <= col_cur;
      row_q   <= row_cur;
      hsub_q  <= hsub_cur;
      vsub_q  <= vsub_cur;
      ccol_q  <= ccol_cur;
      rbase_q <= rbase_cur;
    end
  end

  // Capture/commit; a bad line length takes priority over a frame commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= SEARCH;
      cap_buf     <= '0;
      state       <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (sample)
        cap_buf[idx] <= &rgb_s1;
      case (fsm)
        SEARCH: begin
          if (v_fall) begin
            fsm     <= CAPTURE;
            cap_buf <= '0;
          end
        end
        CAPTURE: begin
          if (h_fall && (col_q != H_LAST)) begin
            sync_err <= 1'b1;
            locked   <= 1'b0;
            fsm      <= SEARCH;
          end else if (v_fall) begin
            if (row_q == V_LAST) begin
              state       <= cap_buf;
              frame_valid <= 1'b1;
              locked      <= 1'b1;
              cap_buf     <= '0;
            end else begin
              sync_err <= 1'b1;
              locked   <= 1'b0;
              fsm      <= SEARCH;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced raster (4x3 cells of 10x10 pixels):
// drives whole frames from a pixel image and predicts commits frame by frame.
module tb_vga_capture;

  localparam int H_TOTAL  = 56;
  localparam int H_VBEGIN = 8;
  localparam int H_ACTIVE = 40;
  localparam int V_TOTAL  = 38;
  localparam int V_VBEGIN = 4;
  localparam int V_ACTIVE = 30;
  localparam int CELL     = 10;
  localparam int GW       = H_ACTIVE / CELL;
  localparam int GH       = V_ACTIVE / CELL;
  localparam int NBITS    = GW * GH;
  localparam int HS_W     = 4;
  localparam int VS_LINES = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hsync = 1'b1;
  logic             vsync = 1'b1;
  logic [3:0]       r_in = '0, g_in = '0, b_in = '0;
  logic [NBITS-1:0] state;
  logic             frame_valid, locked, sync_err;

  vga_capture #(
    .H_TOTAL(H_TOTAL), .H_VBEGIN(H_VBEGIN), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_VBEGIN(V_VBEGIN), .V_ACTIVE(V_ACTIVE),
    .CELL(CELL)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .state(state), .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [11:0]      img [V_ACTIVE][H_ACTIVE];
  logic [NBITS-1:0] exp_state  = '0;
  logic [NBITS-1:0] pend_state = '0;
  bit               m_cap = 1'b0;
  bit               m_locked = 1'b0;
  int               prev_lines = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A cell is lit when all three colour MSBs of its centre pixel are set.
  function automatic logic [NBITS-1:0] model_state();
    logic [NBITS-1:0] s;
    logic [11:0]      px;
    s = '0;
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++) begin
        px = img[r*CELL + CELL/2][c*CELL + CELL/2];
        s[r*GW + c] = px[11] & px[7] & px[3];
      end
    return s;
  endfunction

  task automatic fill_solid(input logic [11:0] col);
    for (int y = 0; y < V_ACTIVE; y++)
      for (int x = 0; x < H_ACTIVE; x++)
        img[y][x] = col;
  endtask

  task automatic set_rect(input int y0, input int y1, input int x0, input int x1,
                          input logic [11:0] col);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        img[y][x] = col;
  endtask

  task automatic fill_random();
    for (int y = 0; y < V_ACTIVE; y++)
      for (int x = 0; x < H_ACTIVE; x++)
        img[y][x] = ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'($urandom);
  endtask

  // Drive one frame starting with a vsync fall; short_line / rst_line < 0 disable.
  task automatic run_frame(input string tag, input int nlines, input int short_line,
                           input int rst_line);
    int          exp_fv, exp_err, seen_fv, seen_err, len;
    logic [11:0] px;
    exp_fv = 0; exp_err = 0; seen_fv = 0; seen_err = 0;
    if (m_cap) begin
      if (prev_lines == V_TOTAL) begin
        exp_fv    = 1;
        exp_state = pend_state;
        m_locked  = 1'b1;
      end else begin
        exp_err  = 1;
        m_locked = 1'b0;
        m_cap    = 1'b0;
      end
    end else begin
      m_cap = 1'b1;
    end
    if (short_line >= 0 && m_cap) begin
      exp_err++;
      m_cap    = 1'b0;
      m_locked = 1'b0;
    end
    if (rst_line >= 0) begin
      m_cap     = 1'b0;
      m_locked  = 1'b0;
      exp_state = '0;
    end
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
      for (int k = 0; k < len; k++) begin
        hsync = (k >= HS_W);
        vsync = (l >= VS_LINES);
        if (l >= V_VBEGIN && l < V_VBEGIN + V_ACTIVE && k >= H_VBEGIN && k < H_VBEGIN + H_ACTIVE)
          px = img[l - V_VBEGIN][k - H_VBEGIN];
        else
          px = 12'h000;
        {r_in, g_in, b_in} = px;
        if (l == rst_line && k == 10) begin
          rst = 1'b1;
          #1;
          check({tag, "_async_rst_state"}, 32'(state), 32'h0);
          check({tag, "_async_rst_locked"}, 32'(locked), 32'h0);
          check({tag, "_async_rst_fv"}, 32'(frame_valid), 32'h0);
        end
        if (l == rst_line && k == 14) rst = 1'b0;
        @(posedge clk);
        #1;
        if (frame_valid) seen_fv++;
        if (sync_err) seen_err++;
      end
    end
    prev_lines = nlines;
    pend_state = model_state();
    check({tag, "_fv_pulses"}, 32'(seen_fv), 32'(exp_fv));
    check({tag, "_err_pulses"}, 32'(seen_err), 32'(exp_err));
    check({tag, "_locked"}, 32'(locked), 32'(m_locked));
    check({tag, "_state"}, 32'(state), 32'(exp_state));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_err", 32'(sync_err), 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    fill_solid(12'hFFF);
    run_frame("f1_white_enter", V_TOTAL, -1, -1);
    run_frame("f2_white_commit", V_TOTAL, -1, -1);

    fill_solid(12'h000);
    set_rect(10, 19, 20, 29, 12'hFFF);
    run_frame("f3_one_cell", V_TOTAL, -1, -1);

    fill_solid(12'h000);
    set_rect(0, 9, 0, 9, 12'hFFF);
    img[5][5] = 12'h000;
    set_rect(0, 9, 10, 19, 12'hFFF);
    img[5][15] = 12'h7F7;
    set_rect(20, 29, 30, 39, 12'hFFF);
    run_frame("f4_border", V_TOTAL, -1, -1);
    check("f3_only_bit6", 32'(state), 32'h040);

    fill_random();
    run_frame("f5_random", V_TOTAL, -1, -1);
    check("f4_bits_0_1_clear_11_set", 32'(state), 32'h800);

    fill_random();
    run_frame("f6_short_line", V_TOTAL, 20, -1);
    fill_random();
    run_frame("f7_reenter", V_TOTAL, -1, -1);
    fill_random();
    run_frame("f8_recover", V_TOTAL, -1, -1);

    fill_random();
    run_frame("f9_short_frame", V_TOTAL - 1, -1, -1);
    fill_random();
    run_frame("f10_frame_err", V_TOTAL, -1, -1);
    fill_random();
    img[5][5] = 12'hFFF;
    run_frame("f11_reenter", V_TOTAL, -1, -1);

    fill_random();
    run_frame("f12_mid_reset", V_TOTAL, -1, 15);
    fill_random();
    run_frame("f13_after_rst", V_TOTAL, -1, -1);
    fill_random();
    run_frame("f14_commit", V_TOTAL, -1, -1);
    fill_random();
    run_frame("f15_commit", V_TOTAL, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
